// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache
module dcache_controller #(
    parameter int LINES = 64,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   dcache_addr,
    input  logic          dcache_re,
    input  logic [3:0]    dcache_we,
    input  logic [31:0]   dcache_din,
    output logic [31:0]   dcache_dout,
    output logic          stall,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_rw,
    output logic [27:0]   mem_req_addr,
    output logic [127:0]  mem_req_data,
    input  logic          mem_resp_valid,
    input  logic [127:0]  mem_resp_data
);

    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];

    logic [27:0] line_q;
    logic [1:0]  off_q;
    logic [31:0] din_q;
    logic [3:0]  we_q;
    logic        re_q;
    logic [31:0] dout_q;

    logic [IDX_W-1:0] in_idx, l_idx;
    logic [TAG_W-1:0] in_tag, l_tag;
    logic [1:0]       in_off;
    logic             store_in, accept, hit;
    logic [31:0]      hit_word, fill_word;
    logic [127:0]     hit_line, fill_line;
    logic             unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] line,
                                              input logic [1:0]   off,
                                              input logic [31:0]  word);
        logic [127:0] res;
        res = line;
        res[{off, 5'b0} +: 32] = word;
        return res;
    endfunction

    assign unused_addr_bits = &{1'b0, dcache_addr[1:0]};

    assign in_idx   = dcache_addr[4 +: IDX_W];
    assign in_tag   = dcache_addr[31 -: TAG_W];
    assign in_off   = dcache_addr[3:2];
    assign l_idx    = line_q[IDX_W-1:0];
    assign l_tag    = line_q[27 -: TAG_W];
    assign store_in = |dcache_we;

    // stall is low in IDLE and RESP, but RESP is the cycle the core wakes up in, so only IDLE accepts
    assign accept   = (state_q == S_IDLE) && (dcache_re || store_in);
    assign hit      = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign hit_word = data_q[in_idx][{in_off, 5'b0} +: 32];
    assign hit_line = put_word(data_q[in_idx], in_off, merge_bytes(hit_word, dcache_din, dcache_we));

    assign fill_word = mem_resp_data[{off_q, 5'b0} +: 32];
    assign fill_line = put_word(mem_resp_data, off_q, merge_bytes(fill_word, din_q, we_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !hit) begin
                    state_d = (valid_q[in_idx] && dirty_q[in_idx]) ? S_WB : S_FILL;
                end
            end
            S_WB:    if (mem_req_ready)  state_d = S_FILL;
            S_FILL:  if (mem_req_ready)  state_d = S_WAIT;
            S_WAIT:  if (mem_resp_valid) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign stall         = (state_q == S_WB) || (state_q == S_FILL) || (state_q == S_WAIT);
    assign mem_req_valid = (state_q == S_WB) || (state_q == S_FILL);
    assign mem_req_rw    = (state_q == S_WB);
    // the victim tag is still in tag_q during WB; it is only replaced when the fill lands
    assign mem_req_addr  = mem_req_rw ? {tag_q[l_idx], l_idx} : line_q;
    assign mem_req_data  = data_q[l_idx];
    assign dcache_dout   = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && hit) begin
                if (store_in)  dirty_q[in_idx] <= 1'b1;
                if (dcache_re) dout_q <= hit_word;
            end
            if (state_q == S_WAIT && mem_resp_valid) begin
                valid_q[l_idx] <= 1'b1;
                dirty_q[l_idx] <= |we_q;
                if (re_q) dout_q <= fill_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line_q <= dcache_addr[31:4];
            off_q  <= in_off;
            din_q  <= dcache_din;
            we_q   <= dcache_we;
            re_q   <= dcache_re;
        end
        if (!reset && accept && hit && store_in) begin
            data_q[in_idx] <= hit_line;
        end
        if (!reset && state_q == S_WAIT && mem_resp_valid) begin
            data_q[l_idx] <= fill_line;
            tag_q[l_idx]  <= l_tag;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller
module tb_dcache_controller;

    localparam int LINES = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    dcache_controller #(.LINES(LINES)) dut (
        .clk(clk), .reset(reset),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rw;
        logic [27:0]  addr;
        logic [127:0] data;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_dout[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] phys_mem [logic [27:0]];
    logic [127:0] ref_mem  [logic [27:0]];
    bit           ref_valid [LINES];
    bit           ref_dirty [LINES];
    logic [21:0]  ref_tag   [LINES];
    logic [127:0] ref_line  [LINES];

    int           hold_cnt = 0;
    bit           hold_seen = 0;
    logic [27:0]  hold_addr;
    int           hold_checks = 0;
    bit           pend_resp = 0;
    bit           resp_block = 0;
    logic [27:0]  pend_addr;
    int           n_req = 0;
    int           n_wb = 0;
    logic         last_rw;
    logic [27:0]  last_addr;
    logic [27:0]  last_wb_addr;
    logic [127:0] last_wb_data;

    function automatic logic [127:0] dflt(input logic [27:0] la);
        return {la[15:0], 16'h3, la[15:0], 16'h2, la[15:0], 16'h1, la[15:0], 16'h0};
    endfunction

    function automatic logic [127:0] phys_get(input logic [27:0] la);
        return phys_mem.exists(la) ? phys_mem[la] : dflt(la);
    endfunction

    function automatic logic [127:0] ref_get(input logic [27:0] la);
        return ref_mem.exists(la) ? ref_mem[la] : dflt(la);
    endfunction

    // memory responder: grants requests (optionally after a hold), checks them against the scoreboard
    always @(negedge clk) begin
        req_t r;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (pend_resp && !resp_block) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = phys_get(pend_addr);
            pend_resp      = 0;
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid === 1'b1) begin
            if (hold_cnt > 0) begin
                if (!hold_seen) begin
                    hold_addr = mem_req_addr;
                    hold_seen = 1;
                end else begin
                    hold_checks++;
                    n_checks++;
                    if (mem_req_addr !== hold_addr || stall !== 1'b1 || mem_req_rw !== 1'b0) begin
                        n_fail++;
                        $display("FAIL hold_stable: addr %h stall %b rw %b, required addr %h stall 1 rw 0",
                                 mem_req_addr, stall, mem_req_rw, hold_addr);
                    end
                end
                hold_cnt--;
            end else begin
                mem_req_ready = 1'b1;
                hold_seen = 0;
                n_req++;
                last_rw   = mem_req_rw;
                last_addr = mem_req_addr;
                n_checks++;
                if (exp_req.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_req: rw %b addr %h, required no request", mem_req_rw, mem_req_addr);
                end else begin
                    r = exp_req.pop_front();
                    if (mem_req_rw !== r.rw || mem_req_addr !== r.addr || (r.rw && mem_req_data !== r.data)) begin
                        n_fail++;
                        $display("FAIL mem_req: rw %b addr %h data %h, required rw %b addr %h data %h",
                                 mem_req_rw, mem_req_addr, mem_req_data, r.rw, r.addr, r.data);
                    end
                end
                if (mem_req_rw) begin
                    phys_mem[mem_req_addr] = mem_req_data;
                    n_wb++;
                    last_wb_addr = mem_req_addr;
                    last_wb_data = mem_req_data;
                end else begin
                    pend_resp = 1;
                    pend_addr = mem_req_addr;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            ref_valid[i] = 0;
            ref_dirty[i] = 0;
        end
    endtask

    task automatic model(input logic [31:0] a, input logic r, input logic [3:0] w,
                         input logic [31:0] d, output bit miss);
        logic [27:0] la;
        int          idx, off;
        logic [21:0] tg;
        req_t        q;
        la   = a[31:4];
        idx  = int'(la[5:0]);
        tg   = la[27:6];
        off  = int'(a[3:2]);
        miss = !(ref_valid[idx] && ref_tag[idx] == tg);
        if (miss) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                q.rw = 1'b1; q.addr = {ref_tag[idx], la[5:0]}; q.data = ref_line[idx];
                exp_req.push_back(q);
                ref_mem[q.addr] = q.data;
            end
            q.rw = 1'b0; q.addr = la; q.data = '0;
            exp_req.push_back(q);
            ref_line[idx]  = ref_get(la);
            ref_tag[idx]   = tg;
            ref_valid[idx] = 1;
            ref_dirty[idx] = 0;
        end
        if (r) exp_dout.push_back(ref_line[idx][off*32 +: 32]);
        if (w != 4'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (w[b]) ref_line[idx][off*32 + b*8 +: 8] = d[b*8 +: 8];
            end
            ref_dirty[idx] = 1;
        end
    endtask

    task automatic access(input logic [31:0] a, input logic r, input logic [3:0] w,
                          input logic [31:0] d, output bit missed);
        bit          mm;
        int          n;
        logic [31:0] e;
        model(a, r, w, d, mm);
        dcache_addr = a; dcache_re = r; dcache_we = w; dcache_din = d;
        @(negedge clk);
        dcache_re = 1'b0; dcache_we = 4'b0;
        dcache_addr = $urandom; dcache_din = $urandom;
        missed = stall;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_timeout: stall %b after %0d cycles, required 0", stall, n);
        end
        n_checks++;
        if (missed !== mm) begin
            n_fail++;
            $display("FAIL miss_flag addr %h: stall seen %b, required %b", a, missed, mm);
        end
        if (r) begin
            e = exp_dout.pop_front();
            n_checks++;
            if (dcache_dout !== e) begin
                n_fail++;
                $display("FAIL load_data addr %h: got %h, required %h", a, dcache_dout, e);
            end
        end
        n_checks++;
        if (exp_req.size() != 0) begin
            n_fail++;
            $display("FAIL missing_req addr %h: %0d requests outstanding, required 0", a, exp_req.size());
            exp_req.delete();
        end
        if (missed) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; dcache_re = 1'b0; dcache_we = 4'b0; dcache_addr = '0; dcache_din = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dcache_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: stall %b valid %b dout %h, required 0 0 0", stall, mem_req_valid, dcache_dout);
        end
    endtask

    task automatic test_read_miss();
        bit m;
        int r0;
        access(32'h10, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (m !== 1'b1 || last_addr !== 28'h1 || last_rw !== 1'b0 || dcache_dout !== 32'hA5A5_0000) begin
            n_fail++;
            $display("FAIL read_miss: stall %b addr %h rw %b dout %h, required 1 0000001 0 a5a50000",
                     m, last_addr, last_rw, dcache_dout);
        end
        r0 = n_req;
        access(32'h10, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (m !== 1'b0 || n_req !== r0 || dcache_dout !== 32'hA5A5_0000) begin
            n_fail++;
            $display("FAIL read_hit: stall %b reqs %0d dout %h, required 0 %0d a5a50000", m, n_req, dcache_dout, r0);
        end
    endtask

    task automatic test_write_hit();
        bit m;
        int r0;
        r0 = n_req;
        access(32'h14, 1'b0, 4'b0011, 32'h1234_5678, m);
        n_checks++;
        if (m !== 1'b0 || dcache_dout !== 32'hA5A5_0000) begin
            n_fail++;
            $display("FAIL store_hold: stall %b dout %h, required 0 a5a50000", m, dcache_dout);
        end
        access(32'h14, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (m !== 1'b0 || n_req !== r0 || dcache_dout !== 32'hA5A5_5678) begin
            n_fail++;
            $display("FAIL write_hit: stall %b reqs %0d dout %h, required 0 %0d a5a55678", m, n_req, dcache_dout, r0);
        end
        access(32'h18, 1'b1, 4'hF, 32'h1111_2222, m);
        access(32'h18, 1'b1, 4'b0, 32'h0, m);
    endtask

    task automatic test_evict();
        bit m;
        int w0;
        access(32'h14 + LINES*16, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (m !== 1'b1 || last_wb_addr !== 28'h1 || last_wb_data[63:32] !== 32'hA5A5_5678) begin
            n_fail++;
            $display("FAIL evict_wb: stall %b addr %h word1 %h, required 1 0000001 a5a55678",
                     m, last_wb_addr, last_wb_data[63:32]);
        end
        w0 = n_wb;
        access(32'h14, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (n_wb !== w0 || dcache_dout !== 32'hA5A5_5678) begin
            n_fail++;
            $display("FAIL reload_clean: writebacks %0d dout %h, required %0d a5a55678", n_wb, dcache_dout, w0);
        end
    endtask

    task automatic test_fill_stall();
        bit m;
        int r0, h0;
        r0 = n_req; h0 = hold_checks;
        hold_cnt = 5;
        access(32'h200, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (n_req - r0 !== 1 || hold_checks - h0 !== 4 || m !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_hold: requests %0d holds %0d stall %b, required 1 4 1", n_req - r0, hold_checks - h0, m);
        end
    endtask

    task automatic test_write_miss();
        bit m;
        int w0;
        w0 = n_wb;
        access(32'h100, 1'b0, 4'hF, 32'hDEAD_BEEF, m);
        n_checks++;
        if (m !== 1'b1 || n_wb !== w0) begin
            n_fail++;
            $display("FAIL write_miss: stall %b writebacks %0d, required 1 %0d", m, n_wb, w0);
        end
        access(32'h100 + LINES*16, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (last_wb_addr !== 28'h10 || last_wb_data[31:0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_miss_wb: addr %h word0 %h, required 0000010 deadbeef", last_wb_addr, last_wb_data[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        bit          m;
        logic [31:0] a;
        logic [3:0]  w;
        int          k;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 2) * LINES + $urandom_range(0, 3)) * 16 + $urandom_range(0, 3) * 4;
            k = $urandom_range(0, 2);
            w = (k == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            access(a, k != 1, w, $urandom, m);
        end
    endtask

    task automatic test_reset_in_wait();
        bit   m;
        req_t q;
        access(32'h14, 1'b1, 4'b0, 32'h0, m);
        q.rw = 1'b0; q.addr = 28'h5; q.data = '0;
        exp_req.push_back(q);
        resp_block = 1;
        dcache_addr = 32'h50; dcache_re = 1'b1; dcache_we = 4'b0;
        @(negedge clk);
        dcache_re = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_state: stall %b valid %b, required 1 0", stall, mem_req_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dcache_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_in_wait: stall %b valid %b dout %h, required 0 0 0", stall, mem_req_valid, dcache_dout);
        end
        reset = 1'b0;
        pend_resp = 0;
        resp_block = 0;
        model_reset();
        n_checks++;
        if (exp_req.size() != 0) begin
            n_fail++;
            $display("FAIL aborted_req: %0d requests outstanding, required 0", exp_req.size());
            exp_req.delete();
        end
        access(32'h14, 1'b1, 4'b0, 32'h0, m);
        n_checks++;
        if (m !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_miss: stall %b, required 1", m);
        end
    endtask

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        phys_mem[28'h1] = {4{32'hA5A5_0000}};
        ref_mem[28'h1]  = {4{32'hA5A5_0000}};
        test_reset();
        test_read_miss();
        test_write_hit();
        test_evict();
        test_fill_stall();
        test_write_miss();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
